// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   D-stage hazard controller for the pipelined MIPS core. It tracks the
//   destination register and remaining Tnew of every in-flight instruction
//   across STAGES downstream stages. From that state it produces the D-stage
//   stall, a forwarding select for each source operand, and the MDU busy
//   interlock.
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   d_valid             D stage holds a real instruction
//   d_a1/d_tuse1        source 1 address / Tuse
//   d_a2/d_tuse2        source 2 address / Tuse
//   d_a3/d_tnew         destination address / Tnew counted from D
//   d_mdureq            D instruction touches HI/LO/MDU
//   d_mdu_start         D instruction is mult/multu/div/divu
//   d_mdu_div           qualifies d_mdu_start as div/divu
//   hold                global freeze of the tracked stages
//   flush               clear all tracked stages
//   stall               freeze PC and F/D, bubble into E (combinational)
//   fwd_sel1/fwd_sel2   0 = register file, k = forward from stage k
//   mdu_busy            MDU busy counter nonzero
//
// Build option
//   HAZARD_STALL_STATS_EN adds the saturating counters stall_cycles and
//   mdu_stall_cycles. The stall logic is the same with or without it.

module hazard_scoreboard #(
  parameter int AW          = 5,
  parameter int TW          = 2,
  parameter int STAGES      = 3,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CW          = 4,
  localparam int SW         = $clog2(STAGES + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          d_valid,
  input  logic [AW-1:0] d_a1,
  input  logic [TW-1:0] d_tuse1,
  input  logic [AW-1:0] d_a2,
  input  logic [TW-1:0] d_tuse2,
  input  logic [AW-1:0] d_a3,
  input  logic [TW-1:0] d_tnew,
  input  logic          d_mdureq,
  input  logic          d_mdu_start,
  input  logic          d_mdu_div,
  input  logic          hold,
  input  logic          flush,
  output logic          stall,
  output logic [SW-1:0] fwd_sel1,
  output logic [SW-1:0] fwd_sel2,
  output logic          mdu_busy
`ifdef HAZARD_STALL_STATS_EN
  ,
  output logic [31:0]   stall_cycles,
  output logic [31:0]   mdu_stall_cycles
`endif
);

  logic [STAGES:1][AW-1:0] a3_q;
  logic [STAGES:1][TW-1:0] t_q;
  logic [CW-1:0]           mdu_cnt_q;

  logic          hit1, hit2;
  logic [TW-1:0] t1, t2;
  logic [SW-1:0] k1, k2;
  logic          req1, req2, mdu_req;
  logic          d_advance;
  logic          mdu_load;

  function automatic logic [TW-1:0] dec_sat(input logic [TW-1:0] v);
    return (v == '0) ? '0 : v - TW'(1);
  endfunction

  // Walk from the oldest stage to the youngest so the youngest match
  // overwrites any older one.
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    t1   = '0;
    t2   = '0;
    k1   = '0;
    k2   = '0;
    for (int k = STAGES; k >= 1; k--) begin
      if (d_a1 != '0 && d_a1 == a3_q[k]) begin
        hit1 = 1'b1;
        t1   = t_q[k];
        k1   = SW'(k);
      end
      if (d_a2 != '0 && d_a2 == a3_q[k]) begin
        hit2 = 1'b1;
        t2   = t_q[k];
        k2   = SW'(k);
      end
    end
  end

  assign req1     = hit1 && (t1 > d_tuse1);
  assign req2     = hit2 && (t2 > d_tuse2);
  assign mdu_busy = (mdu_cnt_q != '0);
  assign mdu_req  = d_mdureq && mdu_busy;
  assign stall    = d_valid && (req1 || req2 || mdu_req);

  // A result still being produced (t != 0) is never forwarded; the operand
  // reads the register file until an older stage holds it with t == 0.
  assign fwd_sel1 = (hit1 && !req1 && t1 == '0) ? k1 : '0;
  assign fwd_sel2 = (hit2 && !req2 && t2 == '0) ? k2 : '0;

  assign d_advance = d_valid && !stall;
  assign mdu_load  = d_advance && d_mdu_start && !hold && !flush;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a3_q <= '0;
      t_q  <= '0;
    end else if (flush) begin
      a3_q <= '0;
      t_q  <= '0;
    end else if (!hold) begin
      // A write to $0 carries no dependency, so it enters as a pure bubble.
      if (d_advance && d_a3 != '0) begin
        a3_q[1] <= d_a3;
        t_q[1]  <= dec_sat(d_tnew);
      end else begin
        a3_q[1] <= '0;
        t_q[1]  <= '0;
      end
      for (int k = 2; k <= STAGES; k++) begin
        a3_q[k] <= a3_q[k-1];
        t_q[k]  <= dec_sat(t_q[k-1]);
      end
    end
  end

  // The MDU keeps computing while the pipeline is held, so it counts down
  // through hold and flush alike.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mdu_cnt_q <= '0;
    end else if (mdu_load) begin
      mdu_cnt_q <= d_mdu_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
    end else if (mdu_cnt_q != '0) begin
      mdu_cnt_q <= mdu_cnt_q - CW'(1);
    end
  end

`ifdef HAZARD_STALL_STATS_EN
  logic stall_counted;
  logic mdu_only;

  assign stall_counted = stall && !hold;
  assign mdu_only      = stall_counted && mdu_req && !req1 && !req2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles     <= '0;
      mdu_stall_cycles <= '0;
    end else begin
      if (stall_counted && stall_cycles != 32'hFFFF_FFFF)
        stall_cycles <= stall_cycles + 32'd1;
      if (mdu_only && mdu_stall_cycles != 32'hFFFF_FFFF)
        mdu_stall_cycles <= mdu_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       d_valid;
  logic [4:0] d_a1, d_a2, d_a3;
  logic [1:0] d_tuse1, d_tuse2, d_tnew;
  logic       d_mdureq, d_mdu_start, d_mdu_div;
  logic       hold, flush;
  logic       stall;
  logic [1:0] fwd_sel1, fwd_sel2;
  logic       mdu_busy;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic       st;
    logic [1:0] f1;
    logic [1:0] f2;
    logic       busy;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .d_valid     (d_valid),
    .d_a1        (d_a1),
    .d_tuse1     (d_tuse1),
    .d_a2        (d_a2),
    .d_tuse2     (d_tuse2),
    .d_a3        (d_a3),
    .d_tnew      (d_tnew),
    .d_mdureq    (d_mdureq),
    .d_mdu_start (d_mdu_start),
    .d_mdu_div   (d_mdu_div),
    .hold        (hold),
    .flush       (flush),
    .stall       (stall),
    .fwd_sel1    (fwd_sel1),
    .fwd_sel2    (fwd_sel2),
    .mdu_busy    (mdu_busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] a1, input logic [1:0] tu1,
                       input logic [4:0] a2, input logic [1:0] tu2,
                       input logic [4:0] a3, input logic [1:0] tn,
                       input logic mreq, input logic mstart, input logic mdiv);
    d_valid = v; d_a1 = a1; d_tuse1 = tu1; d_a2 = a2; d_tuse2 = tu2;
    d_a3 = a3; d_tnew = tn; d_mdureq = mreq; d_mdu_start = mstart; d_mdu_div = mdiv;
  endtask

  // Inputs are already applied; record the expectation, compare on the
  // falling edge, then move to just after the next rising edge.
  task automatic step(input string tag, input logic es, input logic [1:0] ef1,
                      input logic [1:0] ef2, input logic eb);
    exp_t e;
    string t;
    exp_q.push_back({es, ef1, ef2, eb});
    tag_q.push_back(tag);
    @(negedge clk);
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check_eq({t, ".stall"},    {31'd0, stall},    {31'd0, e.st});
    check_eq({t, ".fwd1"},     {30'd0, fwd_sel1}, {30'd0, e.f1});
    check_eq({t, ".fwd2"},     {30'd0, fwd_sel2}, {30'd0, e.f2});
    check_eq({t, ".mdu_busy"}, {31'd0, mdu_busy}, {31'd0, e.busy});
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    hold    = 1'b0;
    flush   = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    check_eq("rst.stall", {31'd0, stall}, 32'd0);
    check_eq("rst.fwd1", {30'd0, fwd_sel1}, 32'd0);
    check_eq("rst.fwd2", {30'd0, fwd_sel2}, 32'd0);
    check_eq("rst.busy", {31'd0, mdu_busy}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Load-use: lw $8 (Tnew 3) then addu reading $8 with Tuse 1.
    drive(1, 0, 0, 0, 0, 8, 3, 0, 0, 0);    step("lw", 0, 0, 0, 0);
    drive(1, 8, 1, 0, 0, 10, 2, 0, 0, 0);   step("addu_stall", 1, 0, 0, 0);
    // lw now in stage 2 with t=1: no stall, not yet forwardable.
    step("addu_go", 0, 0, 0, 0);
    // lw reached stage 3 with t=0; addu $10 in stage 1 with t=1.
    drive(1, 8, 0, 10, 2, 0, 0, 0, 0, 0);   step("rd_old", 0, 3, 0, 0);

    // addu $9 (Tnew 2) followed by sw reading $9 as rt with Tuse 2.
    drive(1, 0, 0, 0, 0, 9, 2, 0, 0, 0);    step("addu9", 0, 0, 0, 0);
    drive(1, 10, 1, 9, 2, 0, 0, 0, 0, 0);   step("sw", 0, 3, 0, 0);
    drive(1, 0, 0, 9, 2, 0, 0, 0, 0, 0);    step("sw_next", 0, 0, 2, 0);

    // $9 in stage 1 (t=1) and stage 2 (t=0): youngest entry decides.
    drive(1, 0, 0, 0, 0, 9, 2, 0, 0, 0);    step("p1", 0, 0, 0, 0);
    step("p2", 0, 0, 0, 0);
    hold = 1'b1;
    drive(1, 9, 1, 0, 0, 0, 0, 0, 0, 0);    step("young_tuse1", 0, 0, 0, 0);
    hold = 1'b0;
    drive(1, 9, 0, 0, 0, 0, 0, 0, 0, 0);    step("young_tuse0", 1, 0, 0, 0);
    step("old_fwd", 0, 2, 0, 0);

    // Writes to $0 are bubbles; $0 sources never match.
    drive(1, 0, 0, 0, 0, 0, 3, 0, 0, 0);    step("bub_in", 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);    step("zero_src", 0, 0, 0, 0);

    // div then mflo: exactly 10 stall cycles.
    drive(1, 0, 0, 0, 0, 0, 0, 1, 1, 1);    step("div", 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 12, 1, 1, 0, 0);
    for (int i = 0; i < 10; i++) step("div_wait", 1, 0, 0, 1);
    step("div_done", 0, 0, 0, 0);

    // mult then mflo: exactly 5 stall cycles.
    drive(1, 0, 0, 0, 0, 0, 0, 1, 1, 0);    step("mult", 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 12, 1, 1, 0, 0);
    for (int i = 0; i < 5; i++) step("mult_wait", 1, 0, 0, 1);
    step("mult_done", 0, 0, 0, 0);

    // Flush on top of a pending load hazard.
    drive(1, 0, 0, 0, 0, 8, 3, 0, 0, 0);    step("lw2", 0, 0, 0, 0);
    flush = 1'b1;
    drive(1, 8, 1, 0, 0, 10, 2, 0, 0, 0);   step("flush_cyc", 1, 0, 0, 0);
    flush = 1'b0;
    step("after_flush", 0, 0, 0, 0);

    // Hold for three cycles in the middle of a div wait.
    drive(1, 0, 0, 0, 0, 0, 0, 1, 1, 1);    step("div2", 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 12, 1, 1, 0, 0);
    for (int i = 0; i < 10; i++) begin
      hold = (i >= 1 && i <= 3);
      step("hold_wait", 1, 0, 0, 1);
    end
    hold = 1'b0;
    step("hold_done", 0, 0, 0, 0);

    // Asynchronous reset in the middle of an MDU stall.
    drive(1, 0, 0, 0, 0, 0, 0, 1, 1, 1);    step("div3", 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 12, 1, 1, 0, 0);   step("pre_rst", 1, 0, 0, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("async_rst.stall", {31'd0, stall}, 32'd0);
    check_eq("async_rst.busy", {31'd0, mdu_busy}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    step("post_rst", 0, 0, 0, 0);

    check_eq("queue_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
